// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its boot loader.
package imem_pkg;

  localparam int unsigned IMEM_WIDTH = 32;
  localparam int unsigned IMEM_DEPTH = 256;
  localparam logic [IMEM_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WR,
    S_CHK,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream, IMEM write and status signals of the boot loader.
interface imem_boot_loader_if #(
  parameter int unsigned LEN_BYTES = 2
);

  logic                              START;
  logic [7:0]                        RX_DATA;
  logic                              RX_VALID;
  logic                              RX_READY;
  logic                              IMEM_WE;
  logic [imem_pkg::IMEM_WIDTH-1:0]   IMEM_ADDR;
  logic [imem_pkg::IMEM_WIDTH-1:0]   IMEM_WDATA;
  logic                              CPU_HOLD;
  logic                              DONE;
  logic                              ERROR;
  logic [LEN_BYTES*8-1:0]            WORD_COUNT;

  modport master (
    input  START, RX_DATA, RX_VALID,
    output RX_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA, CPU_HOLD, DONE, ERROR, WORD_COUNT
  );

  modport slave (
    output START, RX_DATA, RX_VALID,
    input  RX_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA, CPU_HOLD, DONE, ERROR, WORD_COUNT
  );

endinterface

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into a word; nbytes bytes per word.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  clr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  input  logic [2:0]            nbytes,
  output logic [IMEM_WIDTH-1:0] word_c,
  output logic                  last_c
);

  logic [1:0]            cnt_q, cnt_d;
  logic [IMEM_WIDTH-1:0] word_q;

  // word_c already includes the byte accepted this cycle
  always_comb begin
    cnt_d  = cnt_q;
    word_c = word_q;
    last_c = 1'b0;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (byte_valid) begin
      word_c = (cnt_q == 2'd0) ? IMEM_WIDTH'(byte_in)
                               : word_q | (IMEM_WIDTH'(byte_in) << {cnt_q, 3'b000});
      last_c = ((3'(cnt_q) + 3'd1) == nbytes);
      cnt_d  = last_c ? 2'd0 : cnt_q + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_c;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, checksummed program image into IMEM while holding the CPU.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = IMEM_DEPTH,
  parameter int unsigned LEN_BYTES = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  imem_boot_loader_if.master bus
);

  localparam int unsigned LEN_W = LEN_BYTES * 8;

  loader_state_t         state_q, state_d;
  logic [LEN_W-1:0]      n_q, n_d;
  logic [LEN_W-1:0]      wc_q, wc_d;
  logic [7:0]            csum_q, csum_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  we_q, we_d;
  logic [IMEM_WIDTH-1:0] addr_q, addr_d;
  logic [IMEM_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept_c;
  logic                  restart_c;
  logic                  pk_valid_c;
  logic [2:0]            pk_nbytes_c;
  logic [IMEM_WIDTH-1:0] pk_word_c;
  logic                  pk_last_c;
  logic [LEN_W-1:0]      n_new_c;

  assign accept_c    = bus.RX_VALID && rx_ready_q;
  assign restart_c   = bus.START && (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign pk_valid_c  = accept_c && (state_q inside {S_LEN, S_DATA});
  assign pk_nbytes_c = (state_q == S_LEN) ? 3'(LEN_BYTES) : 3'd4;
  assign n_new_c     = pk_word_c[LEN_W-1:0];

  imem_byte_packer u_packer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clr        (restart_c),
    .byte_valid (pk_valid_c),
    .byte_in    (bus.RX_DATA),
    .nbytes     (pk_nbytes_c),
    .word_c     (pk_word_c),
    .last_c     (pk_last_c)
  );

  // Next state plus registered outputs, all derived from the state being entered
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wc_d    = wc_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.START) begin
          state_d = S_LEN;
          wc_d    = '0;
          csum_d  = '0;
        end
      end
      S_LEN: begin
        if (pk_last_c) begin
          n_d = n_new_c;
          if (32'(n_new_c) > MEM_DEPTH) state_d = S_ERR;
          else if (n_new_c == '0)       state_d = S_CHK;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (pk_valid_c) csum_d = csum_q + bus.RX_DATA;
        if (pk_last_c) begin
          state_d = S_WR;
          wdata_d = pk_word_c;
        end
      end
      S_WR: begin
        wc_d    = wc_q + LEN_W'(1);
        state_d = (wc_d == n_q) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (accept_c) state_d = (bus.RX_DATA == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = state_d inside {S_LEN, S_DATA, S_CHK};
    hold_d     = state_d inside {S_LEN, S_DATA, S_WR, S_CHK, S_ERR};
    we_d       = (state_d == S_WR);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    if (state_d == S_WR) addr_d = IMEM_WIDTH'(wc_q) << 2;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      wc_q       <= '0;
      csum_q     <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      wc_q       <= wc_d;
      csum_q     <= csum_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.RX_READY   = rx_ready_q;
  assign bus.IMEM_WE    = we_q;
  assign bus.IMEM_ADDR  = addr_q;
  assign bus.IMEM_WDATA = wdata_q;
  assign bus.CPU_HOLD   = hold_q;
  assign bus.DONE       = done_q;
  assign bus.ERROR      = error_q;
  assign bus.WORD_COUNT = wc_q;

endmodule
